// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Ports: ID bundle in, EX bundle out, flush/cnt_clr in, stall_ID and stall_cnt out.
module id_ex_hazard_stage #(
  parameter int XLEN              = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ID,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic [4:0]      rd_ID,
  input  logic [XLEN-1:0] rs1_data_ID,
  input  logic [XLEN-1:0] rs2_data_ID,
  input  logic [XLEN-1:0] imm_ID,
  input  logic [XLEN-1:0] pc_ID,
  input  logic            reg_WB_ID,
  input  logic            WB_sel_ID,
  input  logic            mem_wr_ID,
  input  logic            branch_ID,
  input  logic            alu_src_ID,
  input  logic [3:0]      alu_op_ID,
  input  logic            flush,
  input  logic            cnt_clr,
  output logic            valid_EX,
  output logic [4:0]      rs1_EX,
  output logic [4:0]      rs2_EX,
  output logic [4:0]      rd_EX,
  output logic [XLEN-1:0] rs1_data_EX,
  output logic [XLEN-1:0] rs2_data_EX,
  output logic [XLEN-1:0] imm_EX,
  output logic [XLEN-1:0] pc_EX,
  output logic            reg_WB_EX,
  output logic            WB_sel_EX,
  output logic            mem_wr_EX,
  output logic            branch_EX,
  output logic            alu_src_EX,
  output logic [3:0]      alu_op_EX,
  output logic            stall_ID,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            reg_wb;
    logic            wb_sel;
    logic            mem_wr;
    logic            branch;
    logic            alu_src;
    logic [3:0]      alu_op;
  } id_ex_t;

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  id_ex_t     ex_q, ex_d, id_b;
  logic       hazard;
  logic       do_flush, do_hold, do_haz;

  assign id_b = '{
    valid:    valid_ID,
    rs1:      rs1_ID,
    rs2:      rs2_ID,
    rd:       rd_ID,
    rs1_data: rs1_data_ID,
    rs2_data: rs2_data_ID,
    imm:      imm_ID,
    pc:       pc_ID,
    reg_wb:   reg_WB_ID,
    wb_sel:   WB_sel_ID,
    mem_wr:   mem_wr_ID,
    branch:   branch_ID,
    alu_src:  alu_src_ID,
    alu_op:   alu_op_ID
  };

  // Load in EX whose destination is read by ID; x0 never counts.
  assign hazard = (state_q == RUN) && valid_ID
                && ex_q.valid && ex_q.wb_sel && ex_q.reg_wb
                && (ex_q.rd != 5'd0)
                && ((ex_q.rd == rs1_ID) || (ex_q.rd == rs2_ID));

  // Mutually exclusive branch conditions; flush dominates.
  assign do_flush = flush;
  assign do_hold  = !flush && (state_q == STALL);
  assign do_haz   = !flush && hazard;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ex_d     = id_b;
    stall_ID = 1'b0;
    unique case (1'b1)
      do_flush: begin
        ex_d    = '0;
        state_d = RUN;
        rem_d   = 2'd0;
      end
      do_hold: begin
        stall_ID = 1'b1;
        ex_d     = '0;
        rem_d    = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      end
      do_haz: begin
        stall_ID = 1'b1;
        ex_d     = '0;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = STALL;
          rem_d   = 2'(LOAD_STALL_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ex_q    <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_ID && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign valid_EX    = ex_q.valid;
  assign rs1_EX      = ex_q.rs1;
  assign rs2_EX      = ex_q.rs2;
  assign rd_EX       = ex_q.rd;
  assign rs1_data_EX = ex_q.rs1_data;
  assign rs2_data_EX = ex_q.rs2_data;
  assign imm_EX      = ex_q.imm;
  assign pc_EX       = ex_q.pc;
  assign reg_WB_EX   = ex_q.reg_wb;
  assign WB_sel_EX   = ex_q.wb_sel;
  assign mem_wr_EX   = ex_q.mem_wr;
  assign branch_EX   = ex_q.branch;
  assign alu_src_EX  = ex_q.alu_src;
  assign alu_op_EX   = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: three instances (1/2/3 stall cycles,
// the third with a 4-bit counter) driven in parallel and checked each cycle.
`timescale 1ns/100ps
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        reg_wb;
    logic        wb_sel;
    logic        mem_wr;
    logic        branch;
    logic        alu_src;
    logic [3:0]  alu_op;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic cnt_clr;
  ex_t  id;

  ex_t         out_ex [3];
  logic        out_st [3];
  logic [15:0] out_cnt[3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] c;
    ex_t  o;
    logic st;
    id_ex_hazard_stage #(
      .XLEN(32), .LOAD_STALL_CYCLES(g + 1), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .valid_ID(id.valid), .rs1_ID(id.rs1), .rs2_ID(id.rs2), .rd_ID(id.rd),
      .rs1_data_ID(id.rs1d), .rs2_data_ID(id.rs2d),
      .imm_ID(id.imm), .pc_ID(id.pc),
      .reg_WB_ID(id.reg_wb), .WB_sel_ID(id.wb_sel), .mem_wr_ID(id.mem_wr),
      .branch_ID(id.branch), .alu_src_ID(id.alu_src), .alu_op_ID(id.alu_op),
      .flush(flush), .cnt_clr(cnt_clr),
      .valid_EX(o.valid), .rs1_EX(o.rs1), .rs2_EX(o.rs2), .rd_EX(o.rd),
      .rs1_data_EX(o.rs1d), .rs2_data_EX(o.rs2d),
      .imm_EX(o.imm), .pc_EX(o.pc),
      .reg_WB_EX(o.reg_wb), .WB_sel_EX(o.wb_sel), .mem_wr_EX(o.mem_wr),
      .branch_EX(o.branch), .alu_src_EX(o.alu_src), .alu_op_EX(o.alu_op),
      .stall_ID(st), .stall_cnt(c)
    );
    assign out_ex[g]  = o;
    assign out_st[g]  = st;
    assign out_cnt[g] = 16'(c);
  end

  // Model: EX contents, bubbles still owed after this cycle, stall count.
  ex_t m_ex  [3];
  int  m_pend[3];
  int  m_cnt [3];

  function automatic logic exp_stall(int i);
    logic use_hit;
    if (!rst_n || flush) return 1'b0;
    if (m_pend[i] > 0) return 1'b1;
    use_hit = id.valid && m_ex[i].valid && m_ex[i].wb_sel
           && m_ex[i].reg_wb && (m_ex[i].rd != 0)
           && (m_ex[i].rd == id.rs1 || m_ex[i].rd == id.rs2);
    return use_hit;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_ex[i]   = '0;
        m_pend[i] = 0;
        m_cnt[i]  = 0;
      end else begin
        logic s;
        int   mx;
        s  = exp_stall(i);
        mx = (i == 2) ? 15 : 65535;
        if (cnt_clr) m_cnt[i] = 0;
        else if (s && m_cnt[i] < mx) m_cnt[i] = m_cnt[i] + 1;
        if (flush) begin
          m_ex[i]   = '0;
          m_pend[i] = 0;
        end else if (s) begin
          m_ex[i]   = '0;
          m_pend[i] = (m_pend[i] > 0) ? m_pend[i] - 1 : i;
        end else begin
          m_ex[i] = id;
        end
      end
    end
  end

  task automatic chk(string nm, int i, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got %h want %h", nm, i, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("ex_regs", i, 256'(out_ex[i]), 256'(m_ex[i]));
      chk("stall_ID", i, 256'(out_st[i]), 256'(exp_stall(i)));
      chk("stall_cnt", i, 256'(out_cnt[i]), 256'(m_cnt[i]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    id        = '0;
    id.valid  = 1'b1;
    id.rs1    = 5'd1;
    id.rd     = rd;
    id.imm    = 32'h10;
    id.pc     = 32'h100;
    id.reg_wb = 1'b1;
    id.wb_sel = 1'b1;
    id.alu_src = 1'b1;
  endtask

  task automatic set_use(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
    id        = '0;
    id.valid  = 1'b1;
    id.rs1    = r1;
    id.rs2    = r2;
    id.rd     = rd;
    id.rs1d   = 32'hAAAA_0000 | 32'(r1);
    id.rs2d   = 32'h5555_0000 | 32'(r2);
    id.pc     = 32'h104;
    id.reg_wb = 1'b1;
    id.alu_op = 4'h3;
  endtask

  task automatic lit(string nm, int i, logic [255:0] act, logic [255:0] exp);
    chk(nm, i, act, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    id      = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      lit("rst_valid", i, 256'(out_ex[i].valid), 256'(0));
      lit("rst_cnt", i, 256'(out_cnt[i]), 256'(0));
    end
    tick;

    // load x5 then dependent add
    set_load(5'd5); tick;
    set_use(5'd5, 5'd6, 5'd7);
    @(negedge clk);
    lit("haz_stall", 0, 256'(out_st[0]), 256'(1));
    lit("haz_stall", 2, 256'(out_st[2]), 256'(1));
    tick;
    @(negedge clk);
    lit("l1_bubble", 0, 256'(out_ex[0].valid), 256'(0));
    lit("l1_nostall", 0, 256'(out_st[0]), 256'(0));
    lit("l2_stall2", 1, 256'(out_st[1]), 256'(1));
    tick;
    @(negedge clk);
    lit("l1_rs1", 0, 256'(out_ex[0].rs1), 256'(5));
    lit("l1_cnt", 0, 256'(out_cnt[0]), 256'(1));
    lit("l2_cnt", 1, 256'(out_cnt[1]), 256'(2));
    lit("l2_bubble", 1, 256'(out_ex[1].valid), 256'(0));
    lit("l3_stall3", 2, 256'(out_st[2]), 256'(1));
    tick;
    @(negedge clk);
    lit("l2_rs1", 1, 256'(out_ex[1].rs1), 256'(5));
    lit("l3_cnt", 2, 256'(out_cnt[2]), 256'(3));
    tick;
    @(negedge clk);
    lit("l3_rs1", 2, 256'(out_ex[2].rs1), 256'(5));
    tick;

    // flush in first STALL cycle of the 3-cycle instance
    set_load(5'd5); tick;
    set_use(5'd5, 5'd0, 5'd8);
    tick;
    flush = 1'b1;
    @(negedge clk);
    lit("flush_nostall", 2, 256'(out_st[2]), 256'(0));
    tick;
    flush = 1'b0;
    @(negedge clk);
    lit("flush_bubble", 2, 256'(out_ex[2].valid), 256'(0));
    lit("flush_run", 2, 256'(out_st[2]), 256'(0));
    tick;
    @(negedge clk);
    lit("flush_capt", 2, 256'(out_ex[2].rd), 256'(8));
    tick;

    // x0 and non-load producers never stall
    set_load(5'd0); tick;
    set_use(5'd0, 5'd0, 5'd9);
    @(negedge clk);
    lit("x0_nostall", 0, 256'(out_st[0]), 256'(0));
    tick;
    set_use(5'd1, 5'd2, 5'd5); tick;
    set_use(5'd3, 5'd5, 5'd10);
    @(negedge clk);
    lit("alu_nostall", 1, 256'(out_st[1]), 256'(0));
    tick;
    set_load(5'd5); tick;
    set_use(5'd5, 5'd5, 5'd11);
    id.valid = 1'b0;
    @(negedge clk);
    lit("inval_nostall", 2, 256'(out_st[2]), 256'(0));
    tick;

    // saturate the 4-bit counter
    for (int k = 0; k < 4; k++) begin
      set_load(5'd5); tick;
      set_use(5'd5, 5'd6, 5'd7);
      repeat (4) tick;
    end
    @(negedge clk);
    lit("sat_cnt", 2, 256'(out_cnt[2]), 256'(15));
    tick;
    set_load(5'd5); tick;
    set_use(5'd5, 5'd6, 5'd7);
    tick;
    @(negedge clk);
    lit("sat_hold", 2, 256'(out_cnt[2]), 256'(15));
    lit("sat_stall", 2, 256'(out_st[2]), 256'(1));
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    @(negedge clk);
    lit("clr_cnt", 2, 256'(out_cnt[2]), 256'(0));
    lit("clr_cnt", 0, 256'(out_cnt[0]), 256'(0));
    repeat (3) tick;

    // async reset in the middle of a stall
    set_load(5'd5); tick;
    set_use(5'd5, 5'd6, 5'd7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      lit("rst_stall", i, 256'(out_st[i]), 256'(0));
      lit("rst_ex", i, 256'(out_ex[i]), 256'(0));
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    lit("post_rst_run", 2, 256'(out_st[2]), 256'(0));
    tick;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      lit("post_rst_capt", i, 256'(out_ex[i].rs1), 256'(5));
    end
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1, bubbles per load-use hazard; legal values 1..3.
REQ-003 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; ports: clk  in  1  clock, rising-edge; rst_n  in  1  async active-low reset.
REQ-005 Ports SHALL be:
valid_ID  in  1  ID holds a real instruction
rs1_ID, rs2_ID, rd_ID  in  5 each  ID register indices
rs1_data_ID, rs2_data_ID, imm_ID, pc_ID  in  XLEN each  ID operands
reg_WB_ID  in  1  writes rd
WB_sel_ID  in  1  load (result from memory)
mem_wr_ID, branch_ID, alu_src_ID  in  1 each  control
alu_op_ID  in  4  ALU opcode
flush  in  1  taken branch/jump resolved in EX; kill ID/EX
cnt_clr  in  1  synchronous clear of stall_cnt
*_EX outputs (valid, rs1, rs2, rd, rs1_data, rs2_data, imm, pc, reg_WB, WB_sel, mem_wr, branch, alu_src, alu_op)  out  same widths  registered ID/EX contents; rs1_EX, rs2_EX, rd_EX, reg_WB_EX, WB_sel_EX feed the forwarding unit
stall_ID  out  1  hold PC and IF/ID this cycle
stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-006 Hazard SHALL be asserted (combinational) when state=RUN, valid_ID=1, valid_EX=1, WB_sel_EX=1, reg_WB_EX=1, rd_EX!=0, and (rd_EX==rs1_ID or rd_EX==rs2_ID).
REQ-007 FSM states SHALL be RUN and STALL, with a 2-bit remaining counter rem.
REQ-008 RUN, no hazard, no flush: on the edge all *_EX registers SHALL capture the *_ID inputs (latency 1 cycle); stall_ID=0.
REQ-009 RUN, hazard, no flush: stall_ID=1 in the same cycle; ID/EX SHALL load a bubble; if LOAD_STALL_CYCLES>1 go to STALL with rem=LOAD_STALL_CYCLES-1, else remain RUN.
REQ-010 STALL: stall_ID=1; ID/EX SHALL load a bubble; rem decrements; when rem==1 at the edge, next state RUN.
REQ-011 Bubble SHALL be all *_EX outputs zero (valid, control, indices, data).
REQ-012 flush=1 SHALL override everything: ID/EX loads a bubble, next state RUN, rem=0, stall_ID=0 that cycle.
REQ-013 Hazard detection SHALL ignore rs indices of x0: rd_EX=0 never stalls.
REQ-014 stall_cnt SHALL increment by 1 on every edge where stall_ID=1, saturate at 2^CNT_W-1, and clear to 0 on cnt_clr (clear wins over increment).
REQ-015 stall_ID SHALL never be asserted with valid_ID=0 in RUN.
REQ-016 The instruction held in ID during a stall SHALL be captured unchanged into ID/EX on the first non-stalled, non-flushed edge.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=RUN, rem=0, all *_EX outputs to 0, stall_cnt=0; stall_ID SHALL read 0 during reset.
REQ-018 Reset asserted mid-STALL SHALL abandon the stall; first edge after release behaves as RUN.

Verification
REQ-019 Load x5 in EX (WB_sel_EX=1, reg_WB_EX=1, rd_EX=5), ID add rs1=5, LOAD_STALL_CYCLES=1 -> stall_ID=1 one cycle, next EX bubble (valid_EX=0), following cycle rs1_EX=5 captured, stall_cnt=1.
REQ-020 Same with LOAD_STALL_CYCLES=2 -> stall_ID=1 for exactly 2 cycles, two bubbles, stall_cnt=2.
REQ-021 Load rd_EX=0 with ID rs1=0 -> no stall; ALU op rd_EX=5 (WB_sel_EX=0) with rs2_ID=5 -> no stall (forwarding handles it).
REQ-022 flush=1 in first STALL cycle with LOAD_STALL_CYCLES=3 -> stall_ID=0 that cycle, valid_EX=0 next, state RUN.
REQ-023 stall_cnt preset to 0xFFFF, further stall -> stays 0xFFFF; cnt_clr with stall same cycle -> 0.
REQ-024 rst_n low for 3 ns mid-STALL, between edges -> all *_EX=0, stall_ID=0 immediately; after release ID instruction captured next edge.
